// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store front end driving a word-wide DataMemory.
// Define MAU_STATS_EN to add saturating load/store/error completion counters.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        is_store_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] load_data_o,
    output logic [31:0] mem_daddr_o,
    output logic [31:0] mem_data_in_o,
    output logic        mem_rd_n_o,
    output logic        mem_wr_n_o,
`ifdef MAU_STATS_EN
    output logic [15:0] load_cnt_o,
    output logic [15:0] store_cnt_o,
    output logic [15:0] err_cnt_o,
`endif
    input  logic [31:0] mem_data_out_i
);
    localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, WRITE = 3'd2, DONE = 3'd3, ERR = 3'd4;
    logic [2:0]  state_q, state_d;
    logic        is_store_q, sext_q, rd_n_q, wr_n_q, bad;
    logic [1:0]  size_q, off_q;
    logic [4:0]  sh;
    logic [31:0] wdata_q, load_data_q, daddr_q, data_in_q, lane, mask, load_val, merged;
    always_comb begin
        bad = size_i == 2'b11 || (size_i == 2'b01 && addr_i[0]) ||
              (size_i == 2'b10 && addr_i[1:0] != 2'b00) || addr_i[31:ADDR_WIDTH] != '0;
        state_d = state_q == IDLE ? (!req_i ? IDLE : bad ? ERR :
                                     (is_store_i && size_i == 2'b10) ? WRITE : READ) :
                  state_q == READ ? (is_store_q ? WRITE : DONE) :
                  state_q == WRITE ? DONE : IDLE;
        // big-endian lanes: byte offset k sits at bits [31-8k -: 8]
        sh = size_q[1] ? 5'd0 : size_q[0] ? {~off_q[1], 4'b0} : {~off_q, 3'b0};
        lane = mem_data_out_i >> sh;
        mask = size_q[1] ? 32'hFFFF_FFFF : size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        load_val = size_q[1] ? lane :
                   size_q[0] ? {{16{sext_q & lane[15]}}, lane[15:0]} :
                               {{24{sext_q & lane[7]}}, lane[7:0]};
        merged = (mem_data_out_i & ~(mask << sh)) | ((wdata_q & mask) << sh);
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            sext_q      <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            load_data_q <= '0;
            daddr_q     <= '0;
            data_in_q   <= '0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
        end else begin
            state_q <= state_d;
            rd_n_q  <= state_d != READ;
            wr_n_q  <= state_d != WRITE;
            if (state_q == IDLE && req_i) begin
                is_store_q <= is_store_i;
                sext_q     <= sign_ext_i;
                size_q     <= size_i;
                off_q      <= addr_i[1:0];
                wdata_q    <= wdata_i;
                if (!bad) daddr_q <= {{(34 - ADDR_WIDTH){1'b0}}, addr_i[ADDR_WIDTH-1:2]};
            end
            if (state_q == READ && !is_store_q) load_data_q <= load_val;
            if (state_d == WRITE) data_in_q <= state_q == READ ? merged : wdata_i;
        end
    end
    assign ready_o       = state_q == IDLE && !reset_i;
    assign done_o        = state_q == DONE || state_q == ERR;
    assign err_o         = state_q == ERR;
    assign load_data_o   = load_data_q;
    assign mem_daddr_o   = daddr_q;
    assign mem_data_in_o = data_in_q;
    assign mem_rd_n_o    = rd_n_q;
    assign mem_wr_n_o    = wr_n_q;
`ifdef MAU_STATS_EN
    logic [15:0] load_cnt_q, store_cnt_q, err_cnt_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (state_q == ERR && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            if (state_q == DONE && is_store_q && store_cnt_q != 16'hFFFF) store_cnt_q <= store_cnt_q + 16'd1;
            if (state_q == DONE && !is_store_q && load_cnt_q != 16'hFFFF) load_cnt_q <= load_cnt_q + 16'd1;
        end
    end
    assign load_cnt_o  = load_cnt_q;
    assign store_cnt_o = store_cnt_q;
    assign err_cnt_o   = err_cnt_q;
`endif
endmodule
